// File: rtl/board_store.sv
// board_store: chess board image store with start-position initialiser.
// After reset (or a startGame edge) the INIT state writes the start position
// one square per cycle (addresses 0..63), then READY accepts single-square
// writes, tracking accepted writes, captures and king captures.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   changePiece  [5:0] address, [9:6] content, [10] write enable
//   currentState user FSM state, 3'b000 = startGame
//   entireBoard  registered board image, square a at [4a+3:4a]
//   ready        high in READY
//   kingCaptured sticky flags, [0] white king taken, [1] black king taken
//   writeCount   accepted writes since last initialisation (wraps)
//   captureCount [3:0] white losses, [7:4] black losses (capture log only)
//   lastCaptured content of most recent victim (capture log only)
//
// Optional feature: define CAPTURE_LOG_EN to build the capture log
// (captureCount / lastCaptured); otherwise both outputs are constant 0.

module board_store (
   input  logic         clk,
   input  logic         reset,
   input  logic [10:0]  changePiece,
   input  logic [2:0]   currentState,
   output logic [255:0] entireBoard,
   output logic         ready,
   output logic [1:0]   kingCaptured,
   output logic [7:0]   writeCount,
   output logic [7:0]   captureCount,
   output logic [3:0]   lastCaptured
);

   typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

   state_t        state_r, state_s;
   logic [5:0]    init_addr_r;
   logic [2:0]    prev_cs_r;
   logic [255:0]  board_r;
   logic          ready_r;
   logic [1:0]    king_r;
   logic [7:0]    wcount_r;

   logic [5:0]    wr_addr_s;
   logic [3:0]    wr_data_s;
   logic [3:0]    old_s;
   logic          restart_s;
   logic          accept_s;
   logic          capture_s;
   logic          king_hit_s;
   logic          init_first_s;

   // Start-position content for a square address {column, row}.
   function automatic logic [3:0] start_square(input logic [5:0] a);
      logic [2:0] back;
      case (a[5:3])
         3'd0, 3'd7: back = 3'b100;   // rook
         3'd1, 3'd6: back = 3'b010;   // knight
         3'd2, 3'd5: back = 3'b011;   // bishop
         3'd3:       back = 3'b101;   // queen
         3'd4:       back = 3'b110;   // king
         default:    back = 3'b000;
      endcase
      case (a[2:0])
         3'd0:    start_square = {1'b1, back};
         3'd1:    start_square = 4'h9;
         3'd6:    start_square = 4'h1;
         3'd7:    start_square = {1'b0, back};
         default: start_square = 4'h0;
      endcase
   endfunction

   assign wr_addr_s    = changePiece[5:0];
   assign wr_data_s    = changePiece[9:6];
   assign old_s        = board_r[{wr_addr_s, 2'b00} +: 4];
   // startGame edge only matters in READY; previous-state register resets to
   // startGame so the first startGame after reset is not an edge.
   assign restart_s    = (state_r == READY) && (currentState == 3'b000) &&
                         (prev_cs_r != 3'b000);
   assign accept_s     = (state_r == READY) && changePiece[10] && !restart_s;
   assign capture_s    = accept_s && (wr_data_s[2:0] != 3'b000) &&
                         (old_s[2:0] != 3'b000) && (old_s[3] != wr_data_s[3]);
   assign king_hit_s   = capture_s && (old_s[2:0] == 3'b110);
   assign init_first_s = (state_r == INIT) && (init_addr_r == 6'd0);

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         INIT: begin
            if (init_addr_r == 6'd63) state_s = READY;
            else                      state_s = INIT;
         end
         READY: begin
            if (restart_s) state_s = INIT;
            else           state_s = READY;
         end
         default: state_s = INIT;
      endcase
   end

   // State register and registered ready flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= INIT;
         ready_r <= 1'b0;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == READY);
      end
   end

   // Board image, init address, edge detector, king flags and write counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         board_r     <= 256'h0;
         init_addr_r <= 6'd0;
         prev_cs_r   <= 3'b000;
         king_r      <= 2'b00;
         wcount_r    <= 8'h00;
      end else begin
         prev_cs_r <= currentState;
         if (state_r == INIT) begin
            board_r[{init_addr_r, 2'b00} +: 4] <= start_square(init_addr_r);
            init_addr_r <= init_addr_r + 6'd1;   // wraps to 0 after 63
            if (init_first_s) begin
               king_r   <= 2'b00;
               wcount_r <= 8'h00;
            end
         end else if (restart_s) begin
            init_addr_r <= 6'd0;
         end else if (accept_s) begin
            board_r[{wr_addr_s, 2'b00} +: 4] <= wr_data_s;
            wcount_r <= wcount_r + 8'h01;
            if (king_hit_s) king_r[old_s[3]] <= 1'b1;
         end
      end
   end

`ifdef CAPTURE_LOG_EN
   logic [7:0] ccount_r;
   logic [3:0] last_r;

   // Capture log: per-colour saturating loss counters and last victim.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ccount_r <= 8'h00;
         last_r   <= 4'h0;
      end else if (init_first_s) begin
         ccount_r <= 8'h00;
         last_r   <= 4'h0;
      end else if (capture_s) begin
         last_r <= old_s;
         if (old_s[3]) begin
            if (ccount_r[7:4] != 4'hF) ccount_r[7:4] <= ccount_r[7:4] + 4'h1;
         end else begin
            if (ccount_r[3:0] != 4'hF) ccount_r[3:0] <= ccount_r[3:0] + 4'h1;
         end
      end
   end

   assign captureCount = ccount_r;
   assign lastCaptured = last_r;
`else
   assign captureCount = 8'h00;
   assign lastCaptured = 4'h0;
`endif

   assign entireBoard  = board_r;
   assign ready        = ready_r;
   assign kingCaptured = king_r;
   assign writeCount   = wcount_r;

endmodule

// File: tb/tb_board_store.sv
// Self-checking bench for board_store: reset values, init latency, start
// position, a table of READY writes (captures, king capture, non-captures),
// re-init with dropped writes, and reset asserted mid-INIT.

module tb_board_store;

`ifdef CAPTURE_LOG_EN
   localparam bit LOG = 1'b1;
`else
   localparam bit LOG = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [10:0]  changePiece;
   logic [2:0]   currentState;
   logic [255:0] entireBoard;
   logic         ready;
   logic [1:0]   kingCaptured;
   logic [7:0]   writeCount;
   logic [7:0]   captureCount;
   logic [3:0]   lastCaptured;

   int checks = 0;
   int failures = 0;

   board_store dut (
      .clk(clk), .reset(reset), .changePiece(changePiece),
      .currentState(currentState), .entireBoard(entireBoard), .ready(ready),
      .kingCaptured(kingCaptured), .writeCount(writeCount),
      .captureCount(captureCount), .lastCaptured(lastCaptured)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic [5:0] addr;
      logic [3:0] data;
      logic [2:0] cs;
      logic [5:0] chk_addr;
      logic [3:0] chk_val;
      logic [7:0] wc;
      logic [1:0] king;
      logic [7:0] cc;   // value with capture log built
      logic [3:0] lc;   // value with capture log built
   } vec_t;

   vec_t vecs[9];
   logic [255:0] start_board;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] sq(input logic [5:0] a);
      return entireBoard[{a, 2'b00} +: 4];
   endfunction

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_board"}, entireBoard, 256'h0);
      check({tag, "_ready"}, {255'h0, ready}, 256'h0);
      check({tag, "_king"}, {254'h0, kingCaptured}, 256'h0);
      check({tag, "_wc"}, {248'h0, writeCount}, 256'h0);
      check({tag, "_cc"}, {248'h0, captureCount}, 256'h0);
      check({tag, "_lc"}, {252'h0, lastCaptured}, 256'h0);
   endtask

   initial begin
      int n;
      logic [2:0] back [8];
      logic [3:0] v;

      // Expected start position built from board geometry.
      back[0] = 3'd4; back[1] = 3'd2; back[2] = 3'd3; back[3] = 3'd5;
      back[4] = 3'd6; back[5] = 3'd3; back[6] = 3'd2; back[7] = 3'd4;
      start_board = 256'h0;
      for (int col = 0; col < 8; col++) begin
         for (int row = 0; row < 8; row++) begin
            if (row == 0)      v = {1'b1, back[col]};
            else if (row == 1) v = 4'h9;
            else if (row == 6) v = 4'h1;
            else if (row == 7) v = {1'b0, back[col]};
            else               v = 4'h0;
            start_board[(col * 8 + row) * 4 +: 4] = v;
         end
      end

      //          we    addr   data  cs      chk    val   wc     king   cc     lc
      vecs[0] = '{1'b1, 6'd38, 4'h0, 3'b000, 6'd38, 4'h0, 8'd1, 2'b00, 8'h00, 4'h0};
      vecs[1] = '{1'b1, 6'd36, 4'h1, 3'b000, 6'd36, 4'h1, 8'd2, 2'b00, 8'h00, 4'h0};
      vecs[2] = '{1'b1, 6'd0,  4'h5, 3'b000, 6'd0,  4'h5, 8'd3, 2'b00, 8'h10, 4'hC};
      vecs[3] = '{1'b1, 6'd32, 4'h1, 3'b000, 6'd32, 4'h1, 8'd4, 2'b10, 8'h20, 4'hE};
      vecs[4] = '{1'b1, 6'd1,  4'h0, 3'b000, 6'd1,  4'h0, 8'd5, 2'b10, 8'h20, 4'hE};
      vecs[5] = '{1'b1, 6'd8,  4'h9, 3'b000, 6'd8,  4'h9, 8'd6, 2'b10, 8'h20, 4'hE};
      vecs[6] = '{1'b1, 6'd36, 4'hB, 3'b000, 6'd36, 4'hB, 8'd7, 2'b10, 8'h21, 4'h1};
      vecs[7] = '{1'b1, 6'd20, 4'h6, 3'b000, 6'd20, 4'h6, 8'd8, 2'b10, 8'h21, 4'h1};
      vecs[8] = '{1'b0, 6'd20, 4'hF, 3'b001, 6'd20, 4'h6, 8'd8, 2'b10, 8'h21, 4'h1};

      // Reset phase.
      reset = 1'b0;
      changePiece = 11'h0;
      currentState = 3'b000;
      #22;
      check_reset_values("reset");

      @(negedge clk) reset = 1'b1;
      wait_ready(n);
      check("init_latency", n, 64);
      check("start_board", entireBoard, start_board);
      check("sq0_black_rook", sq(6'd0), 4'hC);
      check("sq38_white_pawn", sq(6'd38), 4'h1);
      check("start_wc", writeCount, 8'd0);

      // Table-driven READY writes; each vector occupies one cycle.
      for (int i = 0; i < 9; i++) begin
         changePiece = {vecs[i].we, vecs[i].data, vecs[i].addr};
         currentState = vecs[i].cs;
         @(posedge clk); #1;
         check($sformatf("v%0d_sq", i), sq(vecs[i].chk_addr), vecs[i].chk_val);
         check($sformatf("v%0d_wc", i), writeCount, vecs[i].wc);
         check($sformatf("v%0d_king", i), kingCaptured, vecs[i].king);
         check($sformatf("v%0d_cc", i), captureCount, LOG ? vecs[i].cc : 8'h00);
         check($sformatf("v%0d_lc", i), lastCaptured, LOG ? vecs[i].lc : 4'h0);
         check($sformatf("v%0d_ready", i), ready, 1'b1);
      end
      check("sq32_after_seq", sq(6'd32), 4'h1);

      // startGame edge with a coincident write: write dropped, INIT begins.
      changePiece = {1'b1, 4'h1, 6'd63};
      currentState = 3'b000;
      @(posedge clk); #1;
      check("restart_ready_low", ready, 1'b0);
      check("restart_write_dropped_wc", writeCount, 8'd8);
      check("restart_king_held", kingCaptured, 2'b10);
      // Writes during INIT must be ignored.
      changePiece = {1'b1, 4'h7, 6'd10};
      @(posedge clk); #1;
      check("init_first_king_clr", kingCaptured, 2'b00);
      check("init_first_wc_clr", writeCount, 8'd0);
      check("init_first_cc_clr", captureCount, 8'h00);
      check("init_first_lc_clr", lastCaptured, 4'h0);
      wait_ready(n);
      changePiece = 11'h0;
      check("reinit_latency", n + 1, 64);
      check("reinit_board", entireBoard, start_board);
      check("reinit_wc", writeCount, 8'd0);

      // Re-init again, then assert reset at INIT address 20.
      currentState = 3'b001;
      @(posedge clk); #1;
      currentState = 3'b000;
      @(posedge clk); #1;
      check("second_restart", ready, 1'b0);
      repeat (20) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check_reset_values("midinit");
      @(negedge clk) reset = 1'b1;
      wait_ready(n);
      check("post_reset_latency", n, 64);
      check("post_reset_board", entireBoard, start_board);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
